// File: rtl/jelly3_img_bayer_white_balance_ctl.sv
// Frame-synchronous shadow->active parameter scheduler for the Bayer white-balance core.
// Define JELLY3_IMG_WB_CTL_TIMEOUT_EN to force an apply after TIMEOUT cycles waiting in ARMED.
`timescale 1ns/1ps

module jelly3_img_bayer_white_balance_ctl #(
    parameter int OFFSET_BITS = 10,
    parameter int COEFF_BITS  = 14,
    parameter int COEFF_Q     = 10,
    parameter int DATA_BITS   = 32,
    parameter int APPLY_DELAY = 3,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cke,
    input  logic                       img_valid,
    input  logic                       img_row_first,
    input  logic                       img_row_last,
    input  logic                       img_col_first,
    input  logic                       img_col_last,
    input  logic                       s_wr_en,
    input  logic [3:0]                 s_wr_addr,
    input  logic [DATA_BITS-1:0]       s_wr_data,
    input  logic                       update_req,
    input  logic                       update_force,
    output logic                       enable,
    output logic [1:0]                 param_phase,
    output logic [4*OFFSET_BITS-1:0]   param_offset,
    output logic [4*COEFF_BITS-1:0]    param_coeff,
    output logic                       update_ack,
    output logic                       busy,
    output logic                       in_frame,
    output logic                       timeout_flag
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_APPLY = 2'd3;

    localparam int                    DCNT_BITS   = (APPLY_DELAY > 1) ? $clog2(APPLY_DELAY) : 1;
    localparam logic [DCNT_BITS-1:0]  DCNT_LAST   = DCNT_BITS'(APPLY_DELAY - 1);
    localparam logic [COEFF_BITS-1:0] COEFF_UNITY = COEFF_BITS'(1) << COEFF_Q;

    logic                            shadow_enable;
    logic [1:0]                      shadow_phase;
    logic [3:0][OFFSET_BITS-1:0]     shadow_offset;
    logic [3:0][COEFF_BITS-1:0]      shadow_coeff;
    logic [1:0]                      wr_offset_index;
    logic [1:0]                      wr_coeff_index;

    logic                            frame_start;
    logic                            frame_end;

    logic [1:0]                      state;
    logic [1:0]                      state_next;
    logic [DCNT_BITS-1:0]            dcnt;
    logic [DCNT_BITS-1:0]            dcnt_next;
    logic                            apply;

    logic                            unused_bits;

`ifdef JELLY3_IMG_WB_CTL_TIMEOUT_EN
    localparam int                   TCNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_BITS-1:0] TCNT_LAST = TCNT_BITS'(TIMEOUT - 1);

    logic [TCNT_BITS-1:0]            tcnt;
    logic                            timeout_hit;
`endif

    assign unused_bits = ^{s_wr_data, 32'(TIMEOUT)};

    assign wr_offset_index = 2'(s_wr_addr - 4'd1);
    assign wr_coeff_index  = 2'(s_wr_addr - 4'd5);

    // Host writes bypass cke so register access works while the stream is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_enable <= 1'b0;
            shadow_phase  <= 2'd0;
            shadow_offset <= '0;
            shadow_coeff  <= {4{COEFF_UNITY}};
        end else if (s_wr_en) begin
            if (s_wr_addr == 4'd0) begin
                shadow_enable <= s_wr_data[0];
                shadow_phase  <= s_wr_data[2:1];
            end else if (s_wr_addr <= 4'd4) begin
                shadow_offset[wr_offset_index] <= s_wr_data[OFFSET_BITS-1:0];
            end else if (s_wr_addr <= 4'd8) begin
                shadow_coeff[wr_coeff_index] <= s_wr_data[COEFF_BITS-1:0];
            end
        end
    end

    assign frame_start = cke & img_valid & img_row_first & img_col_first;
    assign frame_end   = cke & img_valid & img_row_last  & img_col_last;

    // Frame end wins so a 1x1 frame leaves in_frame low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_frame <= 1'b0;
        end else if (frame_end) begin
            in_frame <= 1'b0;
        end else if (frame_start) begin
            in_frame <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        apply      = 1'b0;
`ifdef JELLY3_IMG_WB_CTL_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        if (update_force) begin
            state_next = ST_IDLE;
            apply      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (update_req) begin
                        if (in_frame) begin
                            state_next = ST_ARMED;
                        end else begin
                            state_next = ST_DELAY;
                            dcnt_next  = '0;
                        end
                    end
                end
                ST_ARMED: begin
                    if (frame_end) begin
                        state_next = ST_DELAY;
                        dcnt_next  = '0;
                    end
`ifdef JELLY3_IMG_WB_CTL_TIMEOUT_EN
                    else if (tcnt == TCNT_LAST) begin
                        state_next  = ST_APPLY;
                        timeout_hit = 1'b1;
                    end
`endif
                end
                ST_DELAY: begin
                    // A new frame before the drain finishes pushes the apply to its end
                    if (frame_end) begin
                        dcnt_next = '0;
                    end else if (frame_start) begin
                        state_next = ST_ARMED;
                    end else if (cke) begin
                        if (dcnt == DCNT_LAST) begin
                            state_next = ST_APPLY;
                        end else begin
                            dcnt_next = dcnt + 1'b1;
                        end
                    end
                end
                ST_APPLY: begin
                    state_next = ST_IDLE;
                    apply      = 1'b1;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            dcnt  <= '0;
        end else begin
            state <= state_next;
            dcnt  <= dcnt_next;
        end
    end

    assign busy = (state != ST_IDLE);

    // The copy samples the shadow before any write landing on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update_ack   <= 1'b0;
            enable       <= 1'b0;
            param_phase  <= 2'd0;
            param_offset <= '0;
            param_coeff  <= {4{COEFF_UNITY}};
        end else begin
            update_ack <= apply;
            if (apply) begin
                enable       <= shadow_enable;
                param_phase  <= shadow_phase;
                param_offset <= shadow_offset;
                param_coeff  <= shadow_coeff;
            end
        end
    end

`ifdef JELLY3_IMG_WB_CTL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if ((state == ST_ARMED) && (state_next == ST_ARMED)) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end else if (update_req) begin
            timeout_flag <= 1'b0;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_jelly3_img_bayer_white_balance_ctl.sv
// Directed self-checking bench for jelly3_img_bayer_white_balance_ctl (APPLY_DELAY=3, TIMEOUT=50).
`timescale 1ns/1ps

module tb_jelly3_img_bayer_white_balance_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic        img_valid;
    logic        img_row_first;
    logic        img_row_last;
    logic        img_col_first;
    logic        img_col_last;
    logic        s_wr_en;
    logic [3:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic        update_req;
    logic        update_force;
    logic        enable;
    logic [1:0]  param_phase;
    logic [39:0] param_offset;
    logic [55:0] param_coeff;
    logic        update_ack;
    logic        busy;
    logic        in_frame;
    logic        timeout_flag;

    int checks    = 0;
    int passes    = 0;
    int ack_count = 0;

    logic             sh_en, exp_en;
    logic [1:0]       sh_ph, exp_ph;
    logic [3:0][9:0]  sh_off, exp_off;
    logic [3:0][13:0] sh_coef, exp_coef;

    jelly3_img_bayer_white_balance_ctl #(
        .OFFSET_BITS (10),
        .COEFF_BITS  (14),
        .COEFF_Q     (10),
        .DATA_BITS   (32),
        .APPLY_DELAY (3),
        .TIMEOUT     (50)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cke           (cke),
        .img_valid     (img_valid),
        .img_row_first (img_row_first),
        .img_row_last  (img_row_last),
        .img_col_first (img_col_first),
        .img_col_last  (img_col_last),
        .s_wr_en       (s_wr_en),
        .s_wr_addr     (s_wr_addr),
        .s_wr_data     (s_wr_data),
        .update_req    (update_req),
        .update_force  (update_force),
        .enable        (enable),
        .param_phase   (param_phase),
        .param_offset  (param_offset),
        .param_coeff   (param_coeff),
        .update_ack    (update_ack),
        .busy          (busy),
        .in_frame      (in_frame),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (update_ack === 1'b1) ack_count <= ack_count + 1;
    end

    task automatic model_reset();
        sh_en   = 1'b0;
        sh_ph   = 2'd0;
        sh_off  = '0;
        sh_coef = {4{14'd1024}};
        exp_en   = sh_en;
        exp_ph   = sh_ph;
        exp_off  = sh_off;
        exp_coef = sh_coef;
    endtask

    task automatic latch_expected();
        exp_en   = sh_en;
        exp_ph   = sh_ph;
        exp_off  = sh_off;
        exp_coef = sh_coef;
    endtask

    task automatic host_write(input logic [3:0] addr, input logic [31:0] data);
        int idx;
        s_wr_en   = 1'b1;
        s_wr_addr = addr;
        s_wr_data = data;
        @(negedge clk);
        s_wr_en = 1'b0;
        if (addr == 4'd0) begin
            sh_en = data[0];
            sh_ph = data[2:1];
        end else if (addr <= 4'd4) begin
            idx = int'(addr) - 1;
            sh_off[idx] = data[9:0];
        end else if (addr <= 4'd8) begin
            idx = int'(addr) - 5;
            sh_coef[idx] = data[13:0];
        end
    endtask

    task automatic clear_stream();
        img_valid     = 1'b0;
        img_row_first = 1'b0;
        img_row_last  = 1'b0;
        img_col_first = 1'b0;
        img_col_last  = 1'b0;
    endtask

    // Streams a full frame at one pixel per clock; returns at the negedge after the last pixel
    task automatic stream_frame(input int rows, input int cols, input int req_a, input int req_b);
        for (int p = 0; p < rows * cols; p++) begin
            img_valid     = 1'b1;
            img_row_first = ((p / cols) == 0);
            img_row_last  = ((p / cols) == rows - 1);
            img_col_first = ((p % cols) == 0);
            img_col_last  = ((p % cols) == cols - 1);
            update_req    = (p == req_a) || (p == req_b);
            @(negedge clk);
        end
        clear_stream();
        update_req = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        cke          = 1'b1;
        s_wr_en      = 1'b0;
        s_wr_addr    = 4'd0;
        s_wr_data    = 32'd0;
        update_req   = 1'b0;
        update_force = 1'b0;
        clear_stream();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({enable, param_phase, param_offset, param_coeff} !== {exp_en, exp_ph, exp_off, exp_coef})
            $display("[TB] FAIL reset_params got en=%b ph=%0d off=%h coeff=%h exp en=%b ph=%0d off=%h coeff=%h",
                     enable, param_phase, param_offset, param_coeff, exp_en, exp_ph, exp_off, exp_coef);
        else passes++;
        checks++;
        if ({busy, update_ack, in_frame, timeout_flag} !== 4'b0000)
            $display("[TB] FAIL reset_flags got busy/ack/in_frame/tflag=%b exp 0000",
                     {busy, update_ack, in_frame, timeout_flag});
        else passes++;
    endtask

    task automatic test_frame_flags();
        img_valid = 1'b1; img_row_first = 1'b1; img_col_first = 1'b1;
        cke = 1'b0;
        @(negedge clk);
        checks++;
        if (in_frame !== 1'b0) $display("[TB] FAIL fs_without_cke got %b exp 0", in_frame);
        else passes++;
        cke = 1'b1;
        @(negedge clk);
        checks++;
        if (in_frame !== 1'b1) $display("[TB] FAIL fs_sets_in_frame got %b exp 1", in_frame);
        else passes++;
        img_row_last = 1'b1; img_col_last = 1'b1;
        @(negedge clk);
        clear_stream();
        checks++;
        if (in_frame !== 1'b0) $display("[TB] FAIL one_pixel_frame got %b exp 0", in_frame);
        else passes++;
    endtask

    task automatic test_idle_apply();
        host_write(4'd3, 32'h0001_0040);
        host_write(4'd6, 32'd2048);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL idle_busy got %b exp 1", busy);
        else passes++;
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) latch_expected();
            checks++;
            if (update_ack !== 1'(k == 5))
                $display("[TB] FAIL idle_ack k=%0d got %b exp %b", k, update_ack, (k == 5));
            else passes++;
            checks++;
            if ({enable, param_phase, param_offset, param_coeff} !== {exp_en, exp_ph, exp_off, exp_coef})
                $display("[TB] FAIL idle_params k=%0d got off=%h coeff=%h exp off=%h coeff=%h",
                         k, param_offset, param_coeff, exp_off, exp_coef);
            else passes++;
            if (k < 6) @(negedge clk);
        end
        checks++;
        if (param_offset[29:20] !== 10'd64 || param_coeff[27:14] !== 14'd2048)
            $display("[TB] FAIL idle_values got off2=%0d coeff1=%0d exp 64 2048",
                     param_offset[29:20], param_coeff[27:14]);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL idle_busy_end got %b exp 0", busy);
        else passes++;
    endtask

    task automatic test_cke_gating();
        int cke_pat [7] = '{0, 0, 1, 0, 1, 1, 0};
        host_write(4'd2, 32'd7);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) latch_expected();
            checks++;
            if (update_ack !== 1'(k == 8))
                $display("[TB] FAIL cke_ack k=%0d got %b exp %b", k, update_ack, (k == 8));
            else passes++;
            checks++;
            if (param_offset !== exp_off)
                $display("[TB] FAIL cke_offset k=%0d got %h exp %h", k, param_offset, exp_off);
            else passes++;
            if (k <= 7) begin
                cke = cke_pat[k-1][0];
                @(negedge clk);
            end
        end
        cke = 1'b1;
    endtask

    task automatic test_mid_frame();
        int c0;
        host_write(4'd5, 32'd1536);
        c0 = ack_count;
        stream_frame(4, 8, 5, 20);
        checks++;
        if (busy !== 1'b1 || in_frame !== 1'b0)
            $display("[TB] FAIL mid_state got busy=%b in_frame=%b exp 1 0", busy, in_frame);
        else passes++;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) latch_expected();
            checks++;
            if (update_ack !== 1'(k == 5))
                $display("[TB] FAIL mid_ack k=%0d got %b exp %b", k, update_ack, (k == 5));
            else passes++;
            checks++;
            if (param_coeff[13:0] !== (k == 5 ? 14'd1536 : 14'd1024))
                $display("[TB] FAIL mid_coeff0 k=%0d got %0d exp %0d", k, param_coeff[13:0],
                         (k == 5 ? 1536 : 1024));
            else passes++;
            @(negedge clk);
        end
        #2;
        checks++;
        if (ack_count - c0 !== 1) $display("[TB] FAIL mid_ack_count got %0d exp 1", ack_count - c0);
        else passes++;
    endtask

    task automatic test_deferral();
        int c0;
        host_write(4'd8, 32'd512);
        c0 = ack_count;
        stream_frame(4, 8, 5, -1);
        @(negedge clk);
        stream_frame(4, 8, -1, -1);
        #2;
        checks++;
        if (ack_count !== c0) $display("[TB] FAIL defer_no_ack got %0d acks exp 0", ack_count - c0);
        else passes++;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) latch_expected();
            checks++;
            if (update_ack !== 1'(k == 5))
                $display("[TB] FAIL defer_ack k=%0d got %b exp %b", k, update_ack, (k == 5));
            else passes++;
            checks++;
            if (param_coeff !== exp_coef)
                $display("[TB] FAIL defer_coeff k=%0d got %h exp %h", k, param_coeff, exp_coef);
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (param_coeff[55:42] !== 14'd512) $display("[TB] FAIL defer_coeff3 got %0d exp 512", param_coeff[55:42]);
        else passes++;
    endtask

    task automatic test_force_collision();
        int c0;
        host_write(4'd1, 32'd5);
        img_valid = 1'b1; img_row_first = 1'b1; img_col_first = 1'b1;
        @(negedge clk);
        img_col_first = 1'b0;
        update_req = 1'b1;
        @(negedge clk);
        clear_stream();
        update_req = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL force_armed got busy=%b exp 1", busy);
        else passes++;
        c0 = ack_count;
        update_force = 1'b1;
        update_req   = 1'b1;
        s_wr_en = 1'b1; s_wr_addr = 4'd0; s_wr_data = 32'd3;
        @(negedge clk);
        update_force = 1'b0; update_req = 1'b0; s_wr_en = 1'b0;
        latch_expected();
        sh_en = 1'b1;
        sh_ph = 2'd1;
        checks++;
        if (update_ack !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL force_ack got ack=%b busy=%b exp 1 0", update_ack, busy);
        else passes++;
        checks++;
        if ({enable, param_phase, param_offset, param_coeff} !== {exp_en, exp_ph, exp_off, exp_coef})
            $display("[TB] FAIL force_params got en=%b ph=%0d off=%h exp en=%b ph=%0d off=%h",
                     enable, param_phase, param_offset, exp_en, exp_ph, exp_off);
        else passes++;
        repeat (9) @(negedge clk);
        #2;
        checks++;
        if (ack_count - c0 !== 1 || busy !== 1'b0)
            $display("[TB] FAIL force_single_ack got acks=%0d busy=%b exp 1 0", ack_count - c0, busy);
        else passes++;
        img_valid = 1'b1; img_row_last = 1'b1; img_col_last = 1'b1;
        @(negedge clk);
        clear_stream();
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        repeat (4) @(negedge clk);
        latch_expected();
        checks++;
        if (update_ack !== 1'b1 || enable !== 1'b1 || param_phase !== 2'd1)
            $display("[TB] FAIL ctrl_apply got ack=%b en=%b ph=%0d exp 1 1 1", update_ack, enable, param_phase);
        else passes++;
    endtask

`ifdef JELLY3_IMG_WB_CTL_TIMEOUT_EN
    task automatic test_timeout();
        host_write(4'd4, 32'd99);
        img_valid = 1'b1; img_row_first = 1'b1; img_col_first = 1'b1;
        @(negedge clk);
        clear_stream();
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        repeat (49) @(negedge clk);
        checks++;
        if (update_ack !== 1'b0 || timeout_flag !== 1'b0)
            $display("[TB] FAIL timeout_k50 got ack=%b flag=%b exp 0 0", update_ack, timeout_flag);
        else passes++;
        @(negedge clk);
        checks++;
        if (timeout_flag !== 1'b1 || busy !== 1'b1)
            $display("[TB] FAIL timeout_k51 got flag=%b busy=%b exp 1 1", timeout_flag, busy);
        else passes++;
        @(negedge clk);
        latch_expected();
        checks++;
        if (update_ack !== 1'b1 || param_offset[39:30] !== 10'd99)
            $display("[TB] FAIL timeout_ack got ack=%b off3=%0d exp 1 99", update_ack, param_offset[39:30]);
        else passes++;
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        checks++;
        if (timeout_flag !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL timeout_clear got flag=%b busy=%b exp 0 1", timeout_flag, busy);
        else passes++;
        update_force = 1'b1;
        @(negedge clk);
        update_force = 1'b0;
        img_valid = 1'b1; img_row_last = 1'b1; img_col_last = 1'b1;
        @(negedge clk);
        clear_stream();
    endtask
`endif

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({enable, param_phase, param_offset, param_coeff} !== {exp_en, exp_ph, exp_off, exp_coef})
            $display("[TB] FAIL async_reset got en=%b ph=%0d off=%h coeff=%h exp en=%b ph=%0d off=%h coeff=%h",
                     enable, param_phase, param_offset, param_coeff, exp_en, exp_ph, exp_off, exp_coef);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_flags();
        test_idle_apply();
        test_cke_gating();
        test_mid_frame();
        test_deferral();
        test_force_collision();
`ifdef JELLY3_IMG_WB_CTL_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/jelly3_img_bayer_white_balance_ctl.md
Name: jelly3_img_bayer_white_balance_ctl

Overview:
- Frame-synchronous parameter scheduler for the Bayer white-balance datapath.
- Host writes go to shadow registers: enable, phase, 4 offsets, 4 coeffs.
- On request, the shadow set is copied atomically to the active outputs once the current frame has fully drained through the 3-stage datapath, so no frame is processed with mixed parameters.
- Sits between the register bus and the white-balance core, and snoops the same image stream timing as the core.

Parameters:
- OFFSET_BITS, 10, offset width.
- COEFF_BITS, 14, coefficient width.
- COEFF_Q, 10, coefficient fraction bits. Reset coeff = 1<<COEFF_Q (unity gain).
- DATA_BITS, 32, host write data width (≥ COEFF_BITS).
- APPLY_DELAY, 3, cke-qualified cycles after the last pixel before the copy; covers datapath depth.
- TIMEOUT, 1000000, cycles in ARMED before a forced apply (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cke  in  1  clock enable, shared with the image stream
- img_valid  in  1  stream valid (snooped)
- img_row_first  in  1  snooped
- img_row_last  in  1  snooped
- img_col_first  in  1  snooped
- img_col_last  in  1  snooped
- s_wr_en  in  1  host write strobe
- s_wr_addr  in  4  0:ctrl{[2:1]phase,[0]enable}, 1-4:offset[0..3], 5-8:coeff[0..3], others ignored
- s_wr_data  in  DATA_BITS  write data, LSB-aligned
- update_req  in  1  request scheduled apply (pulse)
- update_force  in  1  apply on next clk, ignoring frame state
- enable  out  1  active enable
- param_phase  out  2  active phase
- param_offset  out  4xOFFSET_BITS  active offsets
- param_coeff  out  4xCOEFF_BITS  active coeffs
- update_ack  out  1  one-cycle pulse in the cycle the active set changes
- busy  out  1  high while state≠IDLE
- in_frame  out  1  frame in progress
- timeout_flag  out  1  sticky; cleared by the next update_req (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async, any time): state IDLE; all shadow and active regs to enable=0, phase=0, offsets=0, coeffs=1<<COEFF_Q; update_ack=0, busy=0, in_frame=0, timeout_flag=0.
- Host writes ignore cke. They update the shadow only, one cycle latency. Data is truncated to the field width.
- Frame start (fs) = cke & img_valid & img_row_first & img_col_first; sets in_frame.
- Frame end (fe) = cke & img_valid & img_row_last & img_col_last; clears in_frame. If fs and fe coincide (1x1 frame), in_frame ends at 0.
- IDLE: update_req → ARMED if in_frame=1, else → DELAY with counter=0.
- ARMED: fe → DELAY with counter=0.
- DELAY: counter increments on cke. When counter==APPLY_DELAY-1 and cke is high, next state APPLY.
  - fs while in DELAY → back to ARMED. The apply defers to that frame's end.
- APPLY (one cycle):
  - Copy shadow→active.
  - update_ack=1.
  - → IDLE.
- update_force in any state:
  - Copies next cycle, update_ack pulses, state→IDLE.
  - Has priority over update_req in the same cycle.
- update_req while not IDLE is absorbed: no re-arm, no second ack.
- The copy takes shadow values at the APPLY cycle. Writes made in the APPLY cycle itself land in the shadow only and are not copied.
- Total latency from fe to active change: APPLY_DELAY cke cycles + 1 clk.

Optional Feature:
- Macro: JELLY3_IMG_WB_CTL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while ARMED; it is not cke-gated.
  - On reaching TIMEOUT, go to APPLY and set timeout_flag.
  - The counter clears on leaving ARMED.
- Undefined:
  - No counter; ARMED waits indefinitely.
  - timeout_flag is constant 0.

Test Plan:
- Reset check: release reset, no stimulus → enable=0, phase=0, all offsets=0, all coeffs=1024, busy=0.
- Idle apply: with no frame active, write offset[2]=64 and coeff[1]=2048, pulse update_req → update_ack after 3 cke cycles + 1 clk; param_offset[2]=64, param_coeff[1]=2048.
- Mid-frame request: 8x4 frame, write coeff[0]=1536, req at pixel 5 → outputs unchanged until 4 clk after last pixel (cke=1), then 1536.
- Deferral: next frame's fs arrives 2 cycles after fe → no ack. Apply occurs 4 clk after that frame's fe.
- Force and collision: update_force together with update_req while ARMED → immediate ack, state IDLE, exactly one ack. A write to addr 0 in the APPLY cycle is not visible in the outputs.
- Timeout (macro defined, TIMEOUT=50): req while in_frame, no fe for 50 cycles → ack, timeout_flag=1. Next req clears the flag.
